// File: rtl/bht_access_ctrl.sv
// Branch history table port sequencer: INIT sweep, lookup/update arbitration,
// queued saturating read-modify-write of 2-bit counters on a single-port RAM.
// Ports: clk/reset (async active-low); lookup_* in, pred_* out (IF side);
// upd_* in/upd_ready out (EX side); busy, q_count status; tbl_* RAM port.
module bht_access_ctrl #(
  parameter int         IDX_W    = 6,
  parameter int         QDEPTH   = 4,
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      lookup_valid,
  input  logic [IDX_W-1:0]          lookup_idx,
  output logic                      lookup_ready,
  output logic                      pred_valid,
  output logic                      pred_taken,
  input  logic                      upd_valid,
  input  logic [IDX_W-1:0]          upd_idx,
  input  logic                      upd_taken,
  output logic                      upd_ready,
  output logic                      busy,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic [IDX_W-1:0]          tbl_addr,
  output logic                      tbl_re,
  output logic                      tbl_we,
  output logic [1:0]                tbl_wdata,
  input  logic [1:0]                tbl_rdata
);

  localparam int QW = $clog2(QDEPTH);
  localparam logic [QW:0] QFULL = (QW+1)'(QDEPTH);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_URD,
    S_UWR
  } st_t;

  st_t              st, st_nx;
  logic [IDX_W-1:0] init_ptr;
  logic [IDX_W-1:0] q_idx [QDEPTH];
  logic [QDEPTH-1:0] q_dir;
  logic [QW-1:0]    wr_ptr, rd_ptr;
  logic [QW:0]      cnt;
  logic [IDX_W-1:0] op_idx;
  logic             op_dir;
  logic [1:0]       op_cnt;
  logic             pv_q;
  logic             full, empty;
  logic             push, pop, lk_go;
  logic [1:0]       sat_cnt;

  assign full  = (cnt == QFULL);
  assign empty = (cnt == '0);

  assign upd_ready    = (st != S_INIT) && !full;
  assign lookup_ready = (st == S_IDLE) && !full;
  assign busy         = (st == S_INIT);
  assign q_count      = cnt;

  assign push  = upd_valid && upd_ready;
  assign lk_go = lookup_valid && lookup_ready;
  // A full queue steals the port; otherwise lookups have priority.
  assign pop   = (st == S_IDLE) && !empty
               && (full || !lookup_valid);

  assign pred_valid = pv_q;
  assign pred_taken = pv_q & tbl_rdata[1];

  always_comb begin
    sat_cnt = op_cnt;
    unique case (1'b1)
      op_dir && op_cnt != 2'b11:  sat_cnt = op_cnt + 2'd1;
      !op_dir && op_cnt != 2'b00: sat_cnt = op_cnt - 2'd1;
      default:                    sat_cnt = op_cnt;
    endcase
  end

  always_comb begin
    st_nx     = st;
    tbl_addr  = '0;
    tbl_re    = 1'b0;
    tbl_we    = 1'b0;
    tbl_wdata = '0;
    unique case (st)
      S_INIT: begin
        // Gated so no write escapes while reset is held low.
        tbl_we    = reset;
        tbl_addr  = init_ptr;
        tbl_wdata = INIT_CNT;
        if (init_ptr == '1) st_nx = S_IDLE;
      end
      S_IDLE: begin
        if (pop) begin
          tbl_re   = 1'b1;
          tbl_addr = q_idx[rd_ptr];
          st_nx    = S_URD;
        end else if (lk_go) begin
          tbl_re   = 1'b1;
          tbl_addr = lookup_idx;
        end
      end
      S_URD: begin
        tbl_addr = op_idx;
        st_nx    = S_UWR;
      end
      S_UWR: begin
        tbl_we    = 1'b1;
        tbl_addr  = op_idx;
        tbl_wdata = sat_cnt;
        st_nx     = S_IDLE;
      end
      default: st_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= S_INIT;
      init_ptr <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      pv_q     <= 1'b0;
      op_idx   <= '0;
      op_dir   <= 1'b0;
      op_cnt   <= '0;
    end else begin
      st   <= st_nx;
      pv_q <= lk_go;
      cnt  <= cnt + (QW+1)'(push) - (QW+1)'(pop);
      if (st == S_INIT) init_ptr <= init_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        op_idx <= q_idx[rd_ptr];
        op_dir <= q_dir[rd_ptr];
      end
      if (st == S_URD) op_cnt <= tbl_rdata;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr] <= upd_idx;
      q_dir[wr_ptr] <= upd_taken;
    end
  end

endmodule
